// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - two-requester push arbiter with occupancy count for a fifo element chain
// Optional build macro: FIFO_ARB_FIXED_PRIORITY_EN (requester 0 always wins instead of round-robin)
module fifo_push_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] d0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d1,
    output logic             ack1,
    output logic [WIDTH-1:0] fifo_d_in,
    output logic             fifo_in_strobe,
    input  logic             fifo_full,
    input  logic             fifo_out_strobe,
    output logic [CNT_W-1:0] count,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, LOAD, STROBE, SETTLE} state_t;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_t state, state_nxt;
    logic   winner;
    logic   pick;
    logic   grant;
    logic   push;
    logic   pop;

`ifndef FIFO_ARB_FIXED_PRIORITY_EN
    logic   rr;
`endif

    always_comb begin
        grant = (req0 | req1) && !fifo_full && (count < DEPTH_C);
`ifdef FIFO_ARB_FIXED_PRIORITY_EN
        pick  = !req0;
`else
        // pick == 1 selects requester 1; the pointed-to requester wins when it asks
        pick  = rr ? req1 : !req0;
`endif
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = LOAD;
            LOAD:    state_nxt = STROBE;
            STROBE:  state_nxt = SETTLE;
            SETTLE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign push           = (state == STROBE) && (count != DEPTH_C);
    assign pop            = fifo_out_strobe && (count != '0);
    assign fifo_in_strobe = (state == STROBE);
    assign ack0           = fifo_in_strobe && !winner;
    assign ack1           = fifo_in_strobe && winner;
    assign busy           = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            winner    <= 1'b0;
            fifo_d_in <= '0;
            count     <= '0;
        end else begin
            state <= state_nxt;
            // data is captured with the grant so it is visible throughout LOAD
            if (state == IDLE && grant) begin
                winner    <= pick;
                fifo_d_in <= pick ? d1 : d0;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifndef FIFO_ARB_FIXED_PRIORITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rr <= 1'b0;
        else if (state == STROBE)
            rr <= !winner;
    end
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb/tb_fifo_push_arbiter.sv - directed table-driven bench for fifo_push_arbiter
module tb_fifo_push_arbiter;

`ifdef FIFO_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       req0, req1;
    logic [7:0] d0, d1;
    logic       ack0, ack1;
    logic [7:0] fifo_d_in;
    logic       fifo_in_strobe;
    logic       fifo_full;
    logic       fifo_out_strobe;
    logic [2:0] count;
    logic       busy;

    int errors = 0;
    int checks = 0;

    fifo_push_arbiter #(.WIDTH(8), .DEPTH(4), .CNT_W(3)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req0           (req0),
        .d0             (d0),
        .ack0           (ack0),
        .req1           (req1),
        .d1             (d1),
        .ack1           (ack1),
        .fifo_d_in      (fifo_d_in),
        .fifo_in_strobe (fifo_in_strobe),
        .fifo_full      (fifo_full),
        .fifo_out_strobe(fifo_out_strobe),
        .count          (count),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r0, r1;
        logic [7:0]  d0, d1;
        logic        full, pop;
        logic [14:0] exp;   // {ack0, ack1, strobe, fifo_d_in, count, busy}
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t v(input bit r0, input bit r1, input logic [7:0] a, input logic [7:0] b,
                               input bit full, input bit pop, input bit a0, input bit a1, input bit st,
                               input logic [7:0] din, input logic [2:0] cnt, input bit bz);
        vec_t t;
        t.r0 = r0; t.r1 = r1; t.d0 = a; t.d1 = b; t.full = full; t.pop = pop;
        t.exp = {a0, a1, st, din, cnt, bz};
        return t;
    endfunction

    function automatic logic [14:0] outs();
        return {ack0, ack1, fifo_in_strobe, fifo_d_in, count, busy};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (ack0 && ack1) begin
            errors++;
            $display("FAIL ack_exclusive: ack0=%b ack1=%b at %0t", ack0, ack1, $time);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req0 = 0; req1 = 0; d0 = 0; d1 = 0; fifo_full = 0; fifo_out_strobe = 0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        do_reset();
        check("reset_state", 32'(outs()), 32'(15'h0));

        tbl[0]  = v(1,0,8'hAA,8'h00,0,0, 0,0,0,8'hAA,3'd0,1);
        tbl[1]  = v(1,0,8'hAA,8'h00,0,0, 1,0,1,8'hAA,3'd0,1);
        tbl[2]  = v(1,0,8'hAA,8'h00,0,0, 0,0,0,8'hAA,3'd1,1);
        tbl[3]  = v(0,0,8'hAA,8'h00,0,0, 0,0,0,8'hAA,3'd1,0);
        tbl[4]  = v(1,0,8'hBB,8'h00,1,0, 0,0,0,8'hAA,3'd1,0);
        tbl[5]  = v(1,0,8'hBB,8'h00,1,0, 0,0,0,8'hAA,3'd1,0);
        tbl[6]  = v(1,0,8'hBB,8'h00,0,0, 0,0,0,8'hBB,3'd1,1);
        tbl[7]  = v(1,0,8'hBB,8'h00,1,0, 1,0,1,8'hBB,3'd1,1);
        tbl[8]  = v(1,0,8'hBB,8'h00,0,0, 0,0,0,8'hBB,3'd2,1);
        tbl[9]  = v(0,0,8'hBB,8'h00,0,0, 0,0,0,8'hBB,3'd2,0);
        tbl[10] = v(0,1,8'hBB,8'hCC,0,0, 0,0,0,8'hCC,3'd2,1);
        tbl[11] = v(0,1,8'hBB,8'hCC,0,0, 0,1,1,8'hCC,3'd2,1);
        tbl[12] = v(0,1,8'hBB,8'hCC,0,1, 0,0,0,8'hCC,3'd2,1);
        tbl[13] = v(0,0,8'hBB,8'hCC,0,0, 0,0,0,8'hCC,3'd2,0);
        tbl[14] = v(0,0,8'hBB,8'hCC,0,1, 0,0,0,8'hCC,3'd1,0);
        tbl[15] = v(0,0,8'hBB,8'hCC,0,1, 0,0,0,8'hCC,3'd0,0);
        tbl[16] = v(0,0,8'hBB,8'hCC,0,1, 0,0,0,8'hCC,3'd0,0);
        tbl[17] = v(0,0,8'hBB,8'hCC,0,0, 0,0,0,8'hCC,3'd0,0);

        for (int i = 0; i < 18; i++) begin
            req0 = tbl[i].r0; req1 = tbl[i].r1; d0 = tbl[i].d0; d1 = tbl[i].d1;
            fifo_full = tbl[i].full; fifo_out_strobe = tbl[i].pop;
            step();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // both requesters held: alternating grants fill the chain
        do_reset();
        req0 = 1; req1 = 1; d0 = 8'h11; d1 = 8'h22;
        for (int i = 0; i < 4; i++) begin
            automatic bit w = FIXED ? 1'b0 : 1'(i % 2);
            step();
            check($sformatf("alt%0d_din", i), 32'(fifo_d_in), w ? 32'h22 : 32'h11);
            step();
            check($sformatf("alt%0d_ack", i), 32'({ack0, ack1, fifo_in_strobe}), w ? 32'b011 : 32'b101);
            step();
            check($sformatf("alt%0d_cnt", i), 32'(count), 32'(i + 1));
            if (i == 3) req0 = 0;
            step();
        end
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("full_wait%0d", i), 32'({fifo_in_strobe, busy, count}), 32'({2'b00, 3'd4}));
        end
        fifo_out_strobe = 1;
        step();
        fifo_out_strobe = 0;
        check("full_pop_cnt", 32'({busy, count}), 32'({1'b0, 3'd3}));
        step();
        check("full_regrant", 32'({busy, fifo_d_in}), 32'({1'b1, 8'h22}));
        step();
        check("full_ack1", 32'({ack0, ack1, fifo_in_strobe}), 32'b011);
        step();
        check("full_cnt4", 32'(count), 32'd4);
        req1 = 0;
        step();

        // reset asserted during LOAD drops the pending push
        do_reset();
        req0 = 1; d0 = 8'h5A;
        step();
        check("mid_load", 32'({busy, fifo_d_in}), 32'({1'b1, 8'h5A}));
        reset_n = 0;
        #1;
        check("mid_rst_outs", 32'(outs()), 32'(15'h0));
        step();
        check("mid_rst_hold", 32'(outs()), 32'(15'h0));
        reset_n = 1;
        step();
        check("mid_rel_load", 32'({ack0, busy}), 32'b01);
        step();
        check("mid_rel_ack", 32'({ack0, fifo_in_strobe}), 32'b11);
        step();
        req0 = 0;
        check("mid_rel_cnt", 32'(count), 32'd1);
        step();

`ifdef FIFO_ARB_FIXED_PRIORITY_EN
        do_reset();
        req0 = 1; req1 = 1; d0 = 8'h11; d1 = 8'h22;
        for (int i = 0; i < 2; i++) begin
            step();
            step();
            check($sformatf("fix%0d_ack", i), 32'({ack0, ack1}), 32'b10);
            step();
            if (i == 1) req0 = 0;
            step();
        end
        step();
        check("fix_din1", 32'(fifo_d_in), 32'h22);
        step();
        check("fix_ack1", 32'({ack0, ack1}), 32'b01);
        step();
        req1 = 0;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Shares one fifo element chain between two writers (requester 0, requester 1).
- Selects a requester, drives the chain's input data and input strobe, and tracks occupancy from push/pop events.
- Sits directly in front of the first element of the chain; the consumer pops at the chain output independently.

Parameters:
- WIDTH, 8, data width of requesters and chain.
- DEPTH, 4, number of elements in the chain (capacity).
- CNT_W, 3, width of occupancy counter; must hold DEPTH.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 push request; held until ack0.
- d0  input  WIDTH  requester 0 data; stable while req0 high.
- ack0  output  1  one-cycle push accepted for requester 0.
- req1  input  1  requester 1 push request.
- d1  input  WIDTH  requester 1 data.
- ack1  output  1  one-cycle push accepted for requester 1.
- fifo_d_in  output  WIDTH  data to first chain element.
- fifo_in_strobe  output  1  one-cycle load strobe to first chain element.
- fifo_full  input  1  first element used flag (chain cannot accept).
- fifo_out_strobe  input  1  consumer pop strobe at chain output, one cycle per pop.
- count  output  CNT_W  current occupancy.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (async, reset_n low): state IDLE; ack0, ack1, fifo_in_strobe, busy = 0; fifo_d_in = 0; count = 0; rr pointer = 0. Applies mid-transaction: a pending push is dropped with no ack, and the requester keeps req asserted and is re-served after release.
- States: IDLE -> LOAD -> STROBE -> SETTLE -> IDLE.
- IDLE:
  - Grant only if (req0|req1) and !fifo_full and count < DEPTH.
  - Winner: the rr-pointer requester if it requests, else the other.
  - Record the winner and go to LOAD.
- LOAD: fifo_d_in <= winner data; strobe low; busy = 1.
- STROBE:
  - fifo_in_strobe = 1 and ack_winner = 1 in the same cycle, for exactly one cycle.
  - count += 1.
  - rr pointer <= other requester.
- SETTLE:
  - Strobe low for one cycle so the chain shifts the entry onward.
  - fifo_d_in holds its value.
  - Return to IDLE. The next grant decision is made in IDLE on the following cycle.
- Latency: req sampled in IDLE at cycle N -> strobe/ack at N+2. Minimum spacing between pushes is 4 cycles.
- Requester handshake: req and data held stable from assertion through the ack cycle. The requester may deassert req in the cycle after ack. req dropped before ack is a protocol violation and its behaviour is unspecified.
- Counter:
  - fifo_out_strobe with count > 0 decrements.
  - Pop and push in the same cycle leave count unchanged.
  - Pop with count == 0 is ignored; count stays 0.
  - Count never exceeds DEPTH.
- Full boundary: at count == DEPTH, or with fifo_full high, requests wait in IDLE. The request is granted the first IDLE cycle after a pop frees space.
- fifo_full high while in LOAD does not abort the push; the grant decision is final once IDLE is left.
- Both requests continuously asserted: grants alternate 0,1,0,1...
- ack0 and ack1 are never high in the same cycle.

Optional Feature:
- Macro FIFO_ARB_FIXED_PRIORITY_EN.
- Defined: requester 0 always wins when both request; rr pointer removed; requester 1 is served only when req0 is low in IDLE.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Test Plan:
- Reset, then req0=1 with d0=8'hAA -> fifo_d_in=8'hAA from cycle N+1; fifo_in_strobe and ack0 high together at N+2 only; count=1.
- req0 and req1 held high with d0=8'h11, d1=8'h22 -> fifo_d_in sequence 11,22,11,22; ack0/ack1 alternate; never simultaneous.
- Fill to count=4 with req1 still high -> no strobe. Pulse fifo_out_strobe -> count=3, then push proceeds, count=4.
- fifo_out_strobe in the same cycle as fifo_in_strobe at count=2 -> count stays 2. Pop at count=0 -> count stays 0.
- reset_n low during LOAD with req0 high -> outputs 0 immediately, no ack0. After release, ack0 arrives 2 cycles after the first IDLE cycle; count=1.
- FIFO_ARB_FIXED_PRIORITY_EN build, both requests held -> only ack0 pulses. Drop req0 -> ack1 follows.
